// File: rtl/engagement_sequencer.sv
// engagement_sequencer: sits in front of combat_control_unit and drives its
// track/fire commands. The sequence is: start a track on an operator engage
// edge, wait for lock, fire a salvo while the target is in range, and check
// that every fire command is acknowledged by a launch before a timeout.
module engagement_sequencer #(
  parameter logic [13:0] FIRE_RANGE     = 14'd4000,
  parameter logic [1:0]  TTU_LOCKED     = 2'b10,
  parameter logic [15:0] ACQ_TIMEOUT    = 16'd60000,
  parameter logic [15:0] LAUNCH_TIMEOUT = 16'd1000,
  parameter logic [15:0] SHOT_GAP       = 16'd200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        engage_req,
  input  logic        abort,
  input  logic [1:0]  salvo_size,
  input  logic [1:0]  ttu_state,
  input  logic [13:0] distance_to_target,
  input  logic        launch_missile,
  input  logic [3:0]  remaining_missiles,
  output logic        track_target_command,
  output logic        fire_command,
  output logic [2:0]  seq_state,
  output logic [1:0]  shots_fired,
  output logic        engagement_done,
  output logic        fault,
  output logic [1:0]  fault_code
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_ACQUIRE     = 3'd1,
    S_WAIT_RANGE  = 3'd2,
    S_FIRE        = 3'd3,
    S_WAIT_LAUNCH = 3'd4,
    S_GAP         = 3'd5,
    S_DONE        = 3'd6,
    S_FAULT       = 3'd7
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [1:0]  shots_q, shots_d;
  logic [1:0]  code_q, code_d;
  logic        eng_q, eng_prev_q;
  logic        track_q, fire_q, done_q, fault_q;

  logic        start_s;
  logic        locked_s;
  logic        in_range_s;
  logic [1:0]  salvo_eff_s;

  // Input qualifiers: engage edge, lock, weapon range, effective salvo length.
  always_comb begin
    start_s     = eng_q & ~eng_prev_q;
    locked_s    = (ttu_state == TTU_LOCKED);
    in_range_s  = (distance_to_target != 14'd0) && (distance_to_target <= FIRE_RANGE);
    salvo_eff_s = (salvo_size == 2'd0) ? 2'd1 : salvo_size;
  end

  // Next-state, shot counter, fault code and state timer.
  always_comb begin
    state_d = state_q;
    shots_d = shots_q;
    code_d  = code_q;
    if (abort) begin
      // Abort beats everything, including a launch seen this same cycle.
      state_d = S_IDLE;
      code_d  = 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_s && (remaining_missiles == 4'd0)) begin
            state_d = S_FAULT;
            code_d  = 2'd1;
          end else if (start_s) begin
            state_d = S_ACQUIRE;
            shots_d = 2'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ACQUIRE: begin
          if (locked_s) begin
            state_d = S_WAIT_RANGE;
          end else if (timer_q == ACQ_TIMEOUT - 16'd1) begin
            state_d = S_FAULT;
            code_d  = 2'd2;
          end else begin
            state_d = S_ACQUIRE;
          end
        end
        S_WAIT_RANGE: begin
          if (!locked_s) begin
            state_d = S_ACQUIRE;
          end else if (in_range_s) begin
            state_d = S_FIRE;
          end else begin
            state_d = S_WAIT_RANGE;
          end
        end
        S_FIRE: begin
          state_d = S_WAIT_LAUNCH;
        end
        S_WAIT_LAUNCH: begin
          if (launch_missile) begin
            state_d = S_GAP;
            shots_d = shots_q + 2'd1;
          end else if (timer_q == LAUNCH_TIMEOUT - 16'd1) begin
            state_d = S_FAULT;
            code_d  = 2'd3;
          end else begin
            state_d = S_WAIT_LAUNCH;
          end
        end
        S_GAP: begin
          if ((timer_q == SHOT_GAP - 16'd1) &&
              ((shots_q == salvo_eff_s) || (remaining_missiles == 4'd0))) begin
            state_d = S_DONE;
          end else if (timer_q == SHOT_GAP - 16'd1) begin
            state_d = S_WAIT_RANGE;
          end else begin
            state_d = S_GAP;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        S_FAULT: begin
          if (!eng_q) begin
            state_d = S_IDLE;
            code_d  = 2'd0;
          end else begin
            state_d = S_FAULT;
          end
        end
        default: begin
          state_d = S_IDLE;
          code_d  = 2'd0;
        end
      endcase
    end

    // Timer restarts on every state change and saturates otherwise.
    if (state_d != state_q) begin
      timer_d = 16'd0;
    end else if (timer_q == 16'hFFFF) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + 16'd1;
    end
  end

  // State, counters and outputs; outputs are decoded from the next state so
  // they change on the same edge as the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      timer_q    <= 16'd0;
      shots_q    <= 2'd0;
      code_q     <= 2'd0;
      eng_q      <= 1'b0;
      eng_prev_q <= 1'b0;
      track_q    <= 1'b0;
      fire_q     <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      shots_q    <= shots_d;
      code_q     <= code_d;
      eng_q      <= engage_req;
      eng_prev_q <= eng_q;
      track_q    <= (state_d == S_ACQUIRE) || (state_d == S_WAIT_RANGE) ||
                    (state_d == S_FIRE) || (state_d == S_WAIT_LAUNCH) ||
                    (state_d == S_GAP);
      fire_q     <= (state_d == S_FIRE);
      done_q     <= (state_d == S_DONE);
      fault_q    <= (state_d == S_FAULT);
    end
  end

  assign track_target_command = track_q;
  assign fire_command         = fire_q;
  assign seq_state            = state_q;
  assign shots_fired          = shots_q;
  assign engagement_done      = done_q;
  assign fault                = fault_q;
  assign fault_code           = code_q;

endmodule

// File: doc/engagement_sequencer.md
# engagement_sequencer

Automatic engagement controller that sits in front of `combat_control_unit` and drives its `track_target_command` and `fire_command` inputs. It starts a track on an operator engage request and waits for radar lock. It fires a programmable salvo once the target is inside weapon range, and checks each launch acknowledgement against a timeout. It reports completion, abort and fault status back to the operator console.

## Interface
- `FIRE_RANGE`, default 14'd4000: max `distance_to_target` (inclusive) at which a shot may be commanded.
- `TTU_LOCKED`, default 2'b10: `TTU_state` encoding meaning target locked.
- `ACQ_TIMEOUT`, default 16'd60000: cycles allowed from entering ACQUIRE to first lock.
- `LAUNCH_TIMEOUT`, default 16'd1000: cycles allowed from `fire_command` to `launch_missile`.
- `SHOT_GAP`, default 16'd200: cycles held in GAP after each launch.
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `engage_req  in  1`: operator engage, level.
- `abort  in  1`: operator abort, level, highest priority.
- `salvo_size  in  2`: shots per engagement; 0 is treated as 1.
- `ttu_state  in  2`: from CCU `TTU_state`.
- `distance_to_target  in  14`: from CCU.
- `launch_missile  in  1`: from CCU, launch acknowledge.
- `remaining_missiles  in  4`: from CCU.
- `track_target_command  out  1`: to CCU.
- `fire_command  out  1`: to CCU, 1-cycle pulse.
- `seq_state  out  3`: current FSM state.
- `shots_fired  out  2`: launches in the current engagement.
- `engagement_done  out  1`: 1-cycle pulse.
- `fault  out  1`: high while in FAULT.
- `fault_code  out  2`: 1 = no missiles, 2 = acquire timeout, 3 = launch timeout; 0 otherwise.

## Operation
- States and `seq_state` encodings:
  - IDLE = 0, ACQUIRE = 1, WAIT_RANGE = 2, FIRE = 3, WAIT_LAUNCH = 4, GAP = 5, DONE = 6, FAULT = 7.
- The block keeps one 16-bit `timer`. It clears on every state entry and increments each cycle otherwise, saturating at 16'hFFFF.
- `engage_req` is registered. A start is its rising edge, i.e. current = 1 and previous = 0.
- IDLE:
  - On a start with `remaining_missiles == 0`, go to FAULT with code 1.
  - On a start with `remaining_missiles != 0`, go to ACQUIRE and clear `shots_fired`.
- ACQUIRE:
  - If `ttu_state == TTU_LOCKED`, go to WAIT_RANGE.
  - Else if `timer == ACQ_TIMEOUT-1`, go to FAULT with code 2.
- WAIT_RANGE:
  - If `ttu_state != TTU_LOCKED`, go to ACQUIRE (lock lost; the acquire timer restarts).
  - Else if `distance_to_target != 0` and `distance_to_target <= FIRE_RANGE` (unsigned compare), go to FIRE.
- FIRE: lasts exactly one cycle, then goes to WAIT_LAUNCH.
- WAIT_LAUNCH:
  - If `launch_missile`, increment `shots_fired` and go to GAP.
  - Else if `timer == LAUNCH_TIMEOUT-1`, go to FAULT with code 3.
- GAP: after `SHOT_GAP` cycles:
  - If `shots_fired == max(salvo_size, 1)` or `remaining_missiles == 0`, go to DONE.
  - Otherwise go to WAIT_RANGE.
  - The lock check is redone in WAIT_RANGE.
- DONE: assert `engagement_done` for one cycle, then go to IDLE.
- FAULT: hold until `engage_req == 0`, then go to IDLE. `fault_code` clears on exit.
- `abort` high in any state goes to IDLE next cycle.
  - It overrides every other transition, including a same-cycle `launch_missile`; that launch is not counted.
  - No `engagement_done` is issued and `fault_code` is cleared.
- Output decoding:
  - `track_target_command` = 1 in ACQUIRE, WAIT_RANGE, FIRE, WAIT_LAUNCH and GAP; 0 in all other states.
  - `fire_command` = 1 only in FIRE.
- `launch_missile` outside WAIT_LAUNCH is ignored.
- `shots_fired` holds its value after DONE until the next start.

## Timing
- All outputs are registered or decoded from the state register; no input-to-output combinational path.
- Reset values: state IDLE, every output 0, `shots_fired` 0, `timer` 0, registered `engage_req` 0.
- Start latency: rising edge of `engage_req` sampled at edge N gives `track_target_command` = 1 after edge N+1.
- Lock seen at edge M, in range → `fire_command` high in cycle M+2 (WAIT_RANGE at M+1, FIRE at M+2).
- Launch acknowledged at edge L → next possible `fire_command` is no earlier than L+SHOT_GAP+2.
- `engage_req` held high after DONE or FAULT does not restart; a new rising edge is required.
- `rst` mid-engagement drops `track_target_command` and `fire_command` on the next edge.

## Test plan
- Reset, then `engage_req` 0→1 with `remaining_missiles` = 4, `salvo_size` = 2. Lock after 10 cycles, `distance_to_target` = 3000, `launch_missile` 5 cycles after each fire. Expect 2 `fire_command` pulses, `shots_fired` = 2, one `engagement_done` pulse, `track_target_command` 0 after DONE.
- Engage with `remaining_missiles` = 0 → FAULT, `fault_code` = 1, `track_target_command` never high. Drop `engage_req` → IDLE, `fault_code` = 0.
- Never lock → FAULT with `fault_code` = 2 exactly `ACQ_TIMEOUT` cycles after ACQUIRE entry.
- Locked with distance 4001, then 4000 → no fire at 4001, fire at 4000. Distance 0 while locked → no fire.
- Withhold `launch_missile` → `fault_code` = 3 after `LAUNCH_TIMEOUT` cycles. Separately, lose lock in WAIT_RANGE → ACQUIRE, then relock → fire.
- `abort` in the same cycle as `launch_missile` in WAIT_LAUNCH → IDLE next cycle, `shots_fired` not incremented, no `engagement_done`, outputs 0.
